// File: rtl/btn_evt_serializer_pkg.sv
// Shared constants and helpers for the button event serializer.
//   ASCII_PRESS_BASE / ASCII_RELEASE_BASE : event bytes in ASCII mode
//   RAW_STATE_BIT / RAW_IDX_MSB           : bit layout of raw-mode bytes
//   scan_state_e                          : scanner FSM states
//   encode_evt()                          : (index, level) -> event byte
package btn_evt_serializer_pkg;

  localparam logic [7:0] ASCII_PRESS_BASE   = 8'h41;
  localparam logic [7:0] ASCII_RELEASE_BASE = 8'h61;
  localparam int         RAW_STATE_BIT      = 7;
  localparam int         RAW_IDX_MSB        = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  function automatic logic [7:0] encode_evt(input logic [RAW_IDX_MSB:0] idx,
                                            input logic                 pressed,
                                            input logic                 ascii);
    logic [7:0] b;
    if (ascii) begin
      b = (pressed ? ASCII_PRESS_BASE : ASCII_RELEASE_BASE) + {1'b0, idx};
    end else begin
      b = '0;
      b[RAW_STATE_BIT]   = pressed;
      b[RAW_IDX_MSB:0]   = idx;
    end
    return b;
  endfunction

endpackage

// File: rtl/btn_evt_serializer_if.sv
// Report input, event byte stream and status/overflow signals of the
// button event serializer.
//   master : report source / byte consumer (drives rpt_*, out_ack, ovf_clr)
//   slave  : the serializer
interface btn_evt_serializer_if #(
  parameter int N_BTN = 16
);
  logic [N_BTN-1:0] rpt_state;
  logic [N_BTN-1:0] rpt_change;
  logic             rpt_stb;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ack;
  logic             busy;
  logic             ovf;
  logic             ovf_clr;

  modport master (
    output rpt_state, rpt_change, rpt_stb, out_ack, ovf_clr,
    input  out_data, out_valid, busy, ovf
  );

  modport slave (
    input  rpt_state, rpt_change, rpt_stb, out_ack, ovf_clr,
    output out_data, out_valid, busy, ovf
  );
endinterface

// File: rtl/btn_evt_fifo.sv
// 8-bit first-word-fall-through synchronous FIFO, count based.
//   clk, rst          : clock, async active-high reset
//   wr_data, wr_ena   : push (ignored when full)
//   full              : count == DEPTH
//   rd_data, rd_ena   : head word (0 when empty), pop (ignored when empty)
//   empty             : count == 0
module btn_evt_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_ena,
  output logic       full,
  output logic [7:0] rd_data,
  input  logic       rd_ena,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok, rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // full is taken from the current count, so a same-cycle pop cannot
  // make room for a push
  assign wr_ok   = wr_ena & ~full;
  assign rd_ok   = rd_ena & ~empty;
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/btn_evt_serializer.sv
// Button event serializer: turns state/change reports into one byte per
// changed button, buffered in a FIFO and presented on a valid/ack stream.
//   clk, rst : clock, async active-high reset
//   bus      : report input, byte stream, busy, sticky ovf / ovf_clr
//
//   state   | meaning
//   IDLE    | no pending report, new reports are captured
//   SCAN    | emitting one event per cycle from the pending change bits
module btn_evt_serializer
  import btn_evt_serializer_pkg::*;
#(
  parameter int N_BTN      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int ASCII      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_evt_serializer_if.slave  bus
);

  function automatic logic [RAW_IDX_MSB:0] lowest_set(input logic [N_BTN-1:0] v);
    logic [RAW_IDX_MSB:0] idx;
    idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (v[i]) idx = (RAW_IDX_MSB+1)'(i);
    end
    return idx;
  endfunction

  scan_state_e          state_q, state_d;
  logic [N_BTN-1:0]     pend_state_q, pend_state_d;
  logic [N_BTN-1:0]     pend_chg_q, pend_chg_d;
  logic [N_BTN-1:0]     cur_mask, chg_rest;
  logic [RAW_IDX_MSB:0] cur_idx;
  logic                 cur_pressed;
  logic [7:0]           evt_byte;
  logic                 has_change, capture, drop, push;
  logic                 fifo_full, fifo_empty;
  logic                 ovf_q;

  assign has_change  = |bus.rpt_change;
  assign capture     = bus.rpt_stb & has_change & (state_q == ST_IDLE);
  assign drop        = bus.rpt_stb & has_change & (state_q == ST_SCAN);

  assign cur_idx     = lowest_set(pend_chg_q);
  assign cur_mask    = N_BTN'(1) << cur_idx;
  assign chg_rest    = pend_chg_q & ~cur_mask;
  assign cur_pressed = |(pend_state_q & cur_mask);
  assign evt_byte    = encode_evt(cur_idx, cur_pressed, ASCII != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_state_q <= '0;
      pend_chg_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_state_q <= pend_state_d;
      pend_chg_q   <= pend_chg_d;
      // a drop in the same cycle as a clear keeps the flag set
      ovf_q        <= drop | (ovf_q & ~bus.ovf_clr);
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_state_d = pend_state_q;
    pend_chg_d   = pend_chg_q;
    push         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d      = ST_SCAN;
          pend_state_d = bus.rpt_state;
          pend_chg_d   = bus.rpt_change;
        end
      end
      ST_SCAN: begin
        // stall rather than drop while the FIFO is full
        if (!fifo_full) begin
          push       = 1'b1;
          pend_chg_d = chg_rest;
          if (chg_rest == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  btn_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (evt_byte),
    .wr_ena  (push),
    .full    (fifo_full),
    .rd_data (bus.out_data),
    .rd_ena  (bus.out_ack),
    .empty   (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.busy      = (state_q == ST_SCAN);
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_btn_evt_serializer.sv
module tb_btn_evt_serializer;

  localparam int NB  [2] = '{16, 32};
  localparam int DEP [2] = '{4, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] st  [2];
  logic [31:0] chg [2];
  logic        stb [2];
  logic        ack [2];
  logic        clr [2];

  logic [7:0]  od [2];
  logic        ov [2];
  logic        ob [2];
  logic        oo [2];

  btn_evt_serializer_if #(.N_BTN(16)) ifa ();
  btn_evt_serializer_if #(.N_BTN(32)) ifb ();

  assign ifa.rpt_state  = st[0][15:0];
  assign ifa.rpt_change = chg[0][15:0];
  assign ifa.rpt_stb    = stb[0];
  assign ifa.out_ack    = ack[0];
  assign ifa.ovf_clr    = clr[0];
  assign od[0] = ifa.out_data;
  assign ov[0] = ifa.out_valid;
  assign ob[0] = ifa.busy;
  assign oo[0] = ifa.ovf;

  assign ifb.rpt_state  = st[1];
  assign ifb.rpt_change = chg[1];
  assign ifb.rpt_stb    = stb[1];
  assign ifb.out_ack    = ack[1];
  assign ifb.ovf_clr    = clr[1];
  assign od[1] = ifb.out_data;
  assign ov[1] = ifb.out_valid;
  assign ob[1] = ifb.busy;
  assign oo[1] = ifb.ovf;

  btn_evt_serializer #(.N_BTN(16), .FIFO_DEPTH(4), .ASCII(1)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  btn_evt_serializer #(.N_BTN(32), .FIFO_DEPTH(16), .ASCII(0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // event byte for button i at level s: dut 0 is ASCII, dut 1 is raw
  function automatic logic [7:0] enc(input int i, input logic s, input int k);
    logic [6:0] i7;
    i7 = 7'(i);
    if (k == 0) return s ? (8'h41 + {1'b0, i7}) : (8'h61 + {1'b0, i7});
    return {s, i7};
  endfunction

  // model: events not yet in the FIFO, FIFO contents, sticky flag
  logic [7:0] pq  [2][$];
  logic [7:0] fq  [2][$];
  logic       mo  [2];
  logic [7:0] got [2][$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        pq[k].delete();
        fq[k].delete();
        mo[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic bit busy_m = (pq[k].size() != 0);
        automatic bit pop    = (fq[k].size() != 0) && ack[k];
        automatic bit push   = busy_m && (fq[k].size() < DEP[k]);
        automatic bit newrep = stb[k] && (chg[k] != 0);
        mo[k] = (newrep && busy_m) || (mo[k] && !clr[k]);
        if (pop)  void'(fq[k].pop_front());
        if (push) fq[k].push_back(pq[k].pop_front());
        if (newrep && !busy_m) begin
          for (int i = 0; i < NB[k]; i++)
            if (chg[k][i]) pq[k].push_back(enc(i, st[k][i], k));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk("out_valid", k, {31'b0, ov[k]}, {31'b0, fq[k].size() != 0});
        if (fq[k].size() != 0) chk("out_data", k, {24'b0, od[k]}, {24'b0, fq[k][0]});
        chk("busy", k, {31'b0, ob[k]}, {31'b0, pq[k].size() != 0});
        chk("ovf", k, {31'b0, oo[k]}, {31'b0, mo[k]});
        if (ov[k] && ack[k]) got[k].push_back(od[k]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic report(input int k, input logic [31:0] s, input logic [31:0] c);
    st[k]  = s;
    chg[k] = c;
    stb[k] = 1'b1;
    cyc(1);
    stb[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((ob[k] || ov[k]) && n < 300) begin
      cyc(1);
      n++;
    end
    chk("idle_within_bound", k, {30'b0, ob[k], ov[k]}, 32'h0);
  endtask

  initial begin
    int lat;
    for (int k = 0; k < 2; k++) begin
      st[k] = '0; chg[k] = '0; stb[k] = 1'b0; ack[k] = 1'b0; clr[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, {31'b0, ov[k]}, 32'h0);
      chk("rst_busy",  k, {31'b0, ob[k]}, 32'h0);
      chk("rst_ovf",   k, {31'b0, oo[k]}, 32'h0);
      chk("rst_data",  k, {24'b0, od[k]}, 32'h0);
    end
    rst = 1'b0;
    cyc(2);

    // single report, latency 2 cycles
    ack[0] = 1'b1;
    got[0].delete();
    report(0, 32'h1, 32'h1);
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (ov[0]) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 0, lat, 2);
    chk("first_byte", 0, {24'b0, od[0]}, 32'h41);
    cyc(1);
    wait_idle(0);
    chk("single_count", 0, got[0].size(), 1);
    if (got[0].size() > 0) chk("single_byte", 0, {24'b0, got[0][0]}, 32'h41);

    // simultaneous changes
    got[0].delete();
    report(0, 32'h5, 32'h7);
    wait_idle(0);
    chk("simul_count", 0, got[0].size(), 3);
    if (got[0].size() == 3) begin
      chk("simul_b0", 0, {24'b0, got[0][0]}, 32'h41);
      chk("simul_b1", 0, {24'b0, got[0][1]}, 32'h62);
      chk("simul_b2", 0, {24'b0, got[0][2]}, 32'h43);
    end
    chk("simul_ovf", 0, {31'b0, oo[0]}, 32'h0);

    // backpressure with a 4-deep FIFO
    ack[0] = 1'b0;
    got[0].delete();
    report(0, 32'h0, 32'hFFFF);
    cyc(10);
    chk("bp_valid", 0, {31'b0, ov[0]}, 32'h1);
    chk("bp_busy",  0, {31'b0, ob[0]}, 32'h1);
    chk("bp_head",  0, {24'b0, od[0]}, 32'h61);
    ack[0] = 1'b1;
    cyc(16);
    wait_idle(0);
    chk("bp_count", 0, got[0].size(), 16);
    for (int i = 0; i < 16 && i < got[0].size(); i++)
      chk("bp_byte", 0, {24'b0, got[0][i]}, 32'h61 + i);
    chk("bp_ovf", 0, {31'b0, oo[0]}, 32'h0);

    // overlapping report, ovf set/clear priority
    ack[0] = 1'b0;
    got[0].delete();
    report(0, 32'h0, 32'hFFFF);
    cyc(2);
    report(0, 32'h1, 32'h1);
    chk("ovf_set", 0, {31'b0, oo[0]}, 32'h1);
    st[0] = 32'h2; chg[0] = 32'h2; stb[0] = 1'b1; clr[0] = 1'b1;
    cyc(1);
    stb[0] = 1'b0; clr[0] = 1'b0;
    chk("ovf_set_wins", 0, {31'b0, oo[0]}, 32'h1);
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    chk("ovf_clr", 0, {31'b0, oo[0]}, 32'h0);
    ack[0] = 1'b1;
    wait_idle(0);
    chk("ovl_count", 0, got[0].size(), 16);
    if (got[0].size() == 16) begin
      chk("ovl_first", 0, {24'b0, got[0][0]},  32'h61);
      chk("ovl_last",  0, {24'b0, got[0][15]}, 32'h70);
    end

    // reset in the middle of a burst
    report(0, 32'h0, 32'hFFFF);
    cyc(4);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 0, {31'b0, ov[0]}, 32'h0);
    chk("midrst_busy",  0, {31'b0, ob[0]}, 32'h0);
    cyc(1);
    rst = 1'b0;
    got[0].delete();
    cyc(1);
    report(0, 32'h0100, 32'h0100);
    wait_idle(0);
    chk("postrst_count", 0, got[0].size(), 1);
    if (got[0].size() > 0) chk("postrst_byte", 0, {24'b0, got[0][0]}, 32'h49);

    // raw mode, 32 buttons
    ack[1] = 1'b1;
    got[1].delete();
    report(1, 32'h8000_0000, 32'h8000_0001);
    wait_idle(1);
    chk("raw_count", 1, got[1].size(), 2);
    if (got[1].size() == 2) begin
      chk("raw_b0", 1, {24'b0, got[1][0]}, 32'h00);
      chk("raw_b1", 1, {24'b0, got[1][1]}, 32'h9F);
    end

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
